// File: rtl/vsmac_pkg.sv
// rtl/vsmac_pkg.sv - shared widths, saturation limits and the 8-bit reduction helper for vsmac.
// Define VSMAC_SATURATE_EN to clamp products and sums instead of wrapping them.
package vsmac_pkg;

    localparam int DATA_W = 8;
    localparam int PROD_W = 16;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [PROD_W-1:0] prod_t;

    localparam data_t SAT_MAX = 8'sh7F;
    localparam data_t SAT_MIN = 8'sh80;

    function automatic data_t sat8(input prod_t v);
`ifdef VSMAC_SATURATE_EN
        if (v > 16'sd127) begin
            return SAT_MAX;
        end else if (v < -16'sd128) begin
            return SAT_MIN;
        end else begin
            return v[DATA_W-1:0];
        end
`else
        return v[DATA_W-1:0];
`endif
    endfunction

endpackage

// File: rtl/vsmac_lane.sv
// rtl/vsmac_lane.sv - one lane: S1 operand capture, S2 signed product, S3 accumulator.
module vsmac_lane
    import vsmac_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] out_i
);

    data_t s1_a;
    data_t s1_b;
    prod_t s2_prod;
    data_t acc;
    data_t prod_8;
    prod_t sum_w;

    // Sum is formed wide so sat8 sees the true result before reduction.
    always_comb begin
        prod_8 = sat8(s2_prod);
        sum_w  = $signed({{(PROD_W-DATA_W){acc[DATA_W-1]}}, acc})
               + $signed({{(PROD_W-DATA_W){prod_8[DATA_W-1]}}, prod_8});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_a    <= '0;
            s1_b    <= '0;
            s2_prod <= '0;
            acc     <= '0;
        end else if (enable) begin
            s1_a    <= a_i;
            s1_b    <= b;
            s2_prod <= PROD_W'(s1_a) * PROD_W'(s1_b);
            acc     <= sat8(sum_w);
        end
    end

    assign out_i = acc;

endmodule

// File: rtl/vsmac.sv
// rtl/vsmac.sv - vector-scalar MAC top: SIZE independent lanes sharing scalar b.
// Saturating arithmetic is selected with VSMAC_SATURATE_EN.
module vsmac
    import vsmac_pkg::*;
#(
    parameter int SIZE = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [DATA_W*SIZE-1:0]   a,
    input  logic [DATA_W-1:0]        b,
    output logic [DATA_W*SIZE-1:0]   out
);

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        vsmac_lane u_lane (
            .clk    (clk),
            .reset  (reset),
            .enable (enable),
            .a_i    (a[DATA_W*i +: DATA_W]),
            .b      (b),
            .out_i  (out[DATA_W*i +: DATA_W])
        );
    end

endmodule

// File: tb/tb_vsmac.sv
// tb/tb_vsmac.sv - self-checking bench for vsmac at SIZE 1, 3 and 8 against a queue-based model.
module tb_vsmac;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [63:0] a;
    logic [7:0]  b;
    logic [7:0]  out1;
    logic [23:0] out3;
    logic [63:0] out8;

    int passed = 0;
    int total  = 0;

    logic [63:0] qa[$];
    logic [7:0]  qb[$];
    int          acc[8];

    vsmac #(.SIZE(1)) dut1 (.clk(clk), .reset(reset), .enable(enable), .a(a[7:0]),  .b(b), .out(out1));
    vsmac #(.SIZE(3)) dut3 (.clk(clk), .reset(reset), .enable(enable), .a(a[23:0]), .b(b), .out(out3));
    vsmac #(.SIZE(8)) dut8 (.clk(clk), .reset(reset), .enable(enable), .a(a),       .b(b), .out(out8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clamp(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic model_clear();
        qa.delete();
        qb.delete();
        for (int i = 0; i < 8; i++) acc[i] = 0;
    endtask

    // A sample reaches the accumulator two enabled edges after it was captured.
    task automatic model_push(input logic [63:0] av, input logic [7:0] bv);
        logic [63:0] pa;
        logic [7:0]  pb;
        int          p;
        byte         t;
        qa.push_back(av);
        qb.push_back(bv);
        if (qa.size() > 2) begin
            pa = qa.pop_front();
            pb = qb.pop_front();
            for (int i = 0; i < 8; i++) begin
                p = int'($signed(pa[8*i +: 8])) * int'($signed(pb));
`ifdef VSMAC_SATURATE_EN
                acc[i] = clamp(acc[i] + clamp(p));
`else
                t = byte'(acc[i] + p);
                acc[i] = int'(t);
`endif
            end
        end
    endtask

    function automatic logic [63:0] model_out();
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = 8'(acc[i]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        logic [63:0] e;
        e = model_out();
        chk({tag, "_size1"}, {56'b0, out1}, {56'b0, e[7:0]});
        chk({tag, "_size3"}, {40'b0, out3}, {40'b0, e[23:0]});
        chk({tag, "_size8"}, out8, e);
    endtask

    task automatic cycle(input string tag, input logic en, input logic [63:0] av, input logic [7:0] bv);
        enable = en;
        a      = av;
        b      = bv;
        @(posedge clk);
        if (!reset) model_clear();
        else if (en) model_push(av, bv);
        @(negedge clk);
        check_all(tag);
    endtask

    // Reset is asserted between edges and must clear out before any clock arrives.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 model_clear();
        chk({tag, "_async_clear3"}, {40'b0, out3}, 64'h0);
        chk({tag, "_async_clear8"}, out8, 64'h0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b1;
        a      = '0;
        b      = '0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        chk("reset_state", out8, 64'h0);
        reset = 1'b1;

        // 1: back-to-back stream
        cycle("t1", 1'b1, 64'h010407, 8'h01);
        cycle("t1", 1'b1, 64'h020508, 8'h02);
        cycle("t1", 1'b1, 64'h030609, 8'h03);
        chk("t1_v1", {40'b0, out3}, 64'h010407);
        cycle("t1", 1'b1, 64'h0, 8'h00);
        chk("t1_v12", {40'b0, out3}, 64'h050E17);
        cycle("t1", 1'b1, 64'h0, 8'h00);
        chk("t1_v123", {40'b0, out3}, 64'h0E2032);

        // 2: stalls with garbage inputs while enable is low
        do_reset("t2");
        cycle("t2", 1'b1, 64'h010407, 8'h01);
        cycle("t2", 1'b0, {$urandom, $urandom}, 8'($urandom));
        cycle("t2", 1'b1, 64'h020508, 8'h02);
        cycle("t2", 1'b0, {$urandom, $urandom}, 8'($urandom));
        cycle("t2", 1'b1, 64'h030609, 8'h03);
        chk("t2_v1", {40'b0, out3}, 64'h010407);
        cycle("t2", 1'b0, {$urandom, $urandom}, 8'($urandom));
        chk("t2_hold1", {40'b0, out3}, 64'h010407);
        cycle("t2", 1'b1, 64'h0, 8'h00);
        chk("t2_v12", {40'b0, out3}, 64'h050E17);
        cycle("t2", 1'b0, {$urandom, $urandom}, 8'($urandom));
        chk("t2_hold2", {40'b0, out3}, 64'h050E17);
        cycle("t2", 1'b1, 64'h0, 8'h00);
        chk("t2_v123", {40'b0, out3}, 64'h0E2032);

        // 3: signed arithmetic
        do_reset("t3");
        cycle("t3", 1'b1, 64'h010203, 8'hFC);
        cycle("t3", 1'b1, 64'h010203, 8'h04);
        cycle("t3", 1'b1, 64'h03FA09, 8'hFD);
        chk("t3_neg", {40'b0, out3}, 64'hFCF8F4);
        cycle("t3", 1'b1, 64'h0, 8'h00);
        chk("t3_zero", {40'b0, out3}, 64'h000000);
        cycle("t3", 1'b1, 64'h0, 8'h00);
        chk("t3_mixed", {40'b0, out3}, 64'hF712E5);

        // 4: async reset mid-stream, then a fresh stream with no stale products
        for (int i = 0; i < 4; i++) cycle("t4_pre", 1'b1, {$urandom, $urandom}, 8'($urandom));
        do_reset("t4");
        cycle("t4", 1'b1, 64'h010407, 8'h01);
        cycle("t4", 1'b1, 64'h020508, 8'h02);
        cycle("t4", 1'b1, 64'h030609, 8'h03);
        chk("t4_restart_v1", {40'b0, out3}, 64'h010407);
        cycle("t4", 1'b1, 64'h0, 8'h00);
        chk("t4_restart_v12", {40'b0, out3}, 64'h050E17);

        // 5: overflow, 0x7F*0x7F = 0x3F01
        do_reset("t5");
        for (int i = 0; i < 6; i++) cycle("t5", 1'b1, 64'h7F7F7F7F7F7F7F7F, 8'h7F);
`ifdef VSMAC_SATURATE_EN
        chk("t5_sat", {40'b0, out3}, 64'h7F7F7F);
`else
        chk("t5_wrap", {40'b0, out3}, 64'h040404);
`endif

        // 6: random sweep with enable gaps across SIZE 1, 3 and 8
        do_reset("t6");
        for (int i = 0; i < 300; i++) begin
            cycle("t6", ($urandom_range(0, 3) != 0), {$urandom, $urandom}, 8'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
